// File: rtl/fp_uart_cmd_framer.sv
// Byte-stream command framer: UART RX bytes -> opcode + operands on a valid/ready port,
// result -> UART TX bytes MSB first. Define FP_UART_CHECKSUM_EN for XOR-checksummed frames.
module fp_uart_cmd_framer #(
  parameter int OperandWidth  = 32,
  parameter int NumOperands   = 2,
  parameter int ResultWidth   = 32,
  parameter int TimeoutCycles = 1_200_000
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [7:0]                          rx_data_i,
  input  logic                                rx_valid_i,
  output logic                                rx_ready_o,
  output logic [7:0]                          tx_data_o,
  output logic                                tx_valid_o,
  input  logic                                tx_ready_i,
  output logic                                op_valid_o,
  input  logic                                op_ready_i,
  output logic [7:0]                          op_code_o,
  output logic [NumOperands*OperandWidth-1:0] op_data_o,
  input  logic                                res_valid_i,
  output logic                                res_ready_o,
  input  logic [ResultWidth-1:0]              res_data_i,
  output logic                                frame_err_o
);

  localparam int OpW     = NumOperands * OperandWidth;
  localparam int OpBytes = OpW / 8;
`ifdef FP_UART_CHECKSUM_EN
  localparam int CsBytes = 1;
`else
  localparam int CsBytes = 0;
`endif
  localparam bit CsEn    = (CsBytes != 0);
  localparam int RxBytes = OpBytes + CsBytes;
  localparam int TxW     = ResultWidth + 8 * CsBytes;
  localparam int TxBytes = TxW / 8;
  localparam int CntW    = $clog2(RxBytes + 1);
  localparam int TxCntW  = $clog2(TxBytes + 1);
  localparam int ToW     = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;

  if (OperandWidth % 8 != 0) begin : g_bad_operand_width
    $error("OperandWidth must be a multiple of 8");
  end
  if (ResultWidth % 8 != 0) begin : g_bad_result_width
    $error("ResultWidth must be a multiple of 8");
  end
  if (NumOperands < 1 || NumOperands > 4) begin : g_bad_num_operands
    $error("NumOperands must be in 1..4");
  end

  typedef enum logic [2:0] {IDLE, COLLECT, ISSUE, WAIT_RES, SEND} state_t;

  state_t              state;
  logic [CntW-1:0]     byte_cnt;
  logic [ToW-1:0]      to_cnt;
  logic [TxW-1:0]      tx_sh;
  logic [TxCntW-1:0]   tx_left;
  logic [TxW-1:0]      res_pack;
  logic                rx_fire, tx_fire, last_byte, timeout_hit, csum_bad;

  assign rx_fire     = rx_valid_i && rx_ready_o;
  assign tx_fire     = tx_valid_o && tx_ready_i;
  assign last_byte   = (byte_cnt == CntW'(RxBytes - 1));
  assign timeout_hit = (TimeoutCycles != 0) && (to_cnt == ToW'(TimeoutCycles));
  // The outgoing byte is always the top byte of the shift register.
  assign tx_data_o   = tx_sh[TxW-1 -: 8];

`ifdef FP_UART_CHECKSUM_EN
  logic [7:0] csum;

  function automatic logic [7:0] xor_bytes(input logic [ResultWidth-1:0] v);
    logic [7:0] acc;
    acc = '0;
    for (int i = 0; i < ResultWidth / 8; i++) acc ^= v[8*i +: 8];
    return acc;
  endfunction

  assign res_pack = {res_data_i, xor_bytes(res_data_i)};
  assign csum_bad = (csum != rx_data_i);
`else
  assign res_pack = res_data_i;
  assign csum_bad = 1'b0;
`endif

  // NOTE: every register here uses <= so all updates see the same pre-edge values;
  // blocking assignments would make the result depend on statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      byte_cnt    <= '0;
      to_cnt      <= '0;
      tx_sh       <= '0;
      tx_left     <= '0;
      rx_ready_o  <= 1'b0;
      tx_valid_o  <= 1'b0;
      op_valid_o  <= 1'b0;
      res_ready_o <= 1'b0;
      op_code_o   <= '0;
      op_data_o   <= '0;
      frame_err_o <= 1'b0;
`ifdef FP_UART_CHECKSUM_EN
      csum        <= '0;
`endif
    end else begin
      frame_err_o <= 1'b0;
      unique case (state)
        IDLE: begin
          rx_ready_o <= 1'b1;
          if (rx_fire) begin
            op_code_o <= rx_data_i;
            byte_cnt  <= '0;
            to_cnt    <= '0;
            state     <= COLLECT;
`ifdef FP_UART_CHECKSUM_EN
            csum      <= rx_data_i;
`endif
          end
        end
        COLLECT: begin
          if (timeout_hit) begin
            // A byte arriving in this cycle is swallowed with the aborted frame.
            frame_err_o <= 1'b1;
            op_code_o   <= '0;
            op_data_o   <= '0;
            state       <= IDLE;
          end else if (rx_fire) begin
            to_cnt   <= '0;
            byte_cnt <= byte_cnt + CntW'(1);
            if (!(CsEn && last_byte)) op_data_o <= (op_data_o << 8) | OpW'(rx_data_i);
`ifdef FP_UART_CHECKSUM_EN
            csum     <= csum ^ rx_data_i;
`endif
            if (last_byte) begin
              rx_ready_o <= 1'b0;
              if (CsEn && csum_bad) begin
                frame_err_o <= 1'b1;
                tx_sh       <= TxW'(8'hEE) << (TxW - 8);
                tx_left     <= '0;
                tx_valid_o  <= 1'b1;
                state       <= SEND;
              end else begin
                op_valid_o <= 1'b1;
                state      <= ISSUE;
              end
            end
          end else if (TimeoutCycles != 0) begin
            to_cnt <= to_cnt + ToW'(1);
          end
        end
        ISSUE: begin
          if (op_valid_o && op_ready_i) begin
            op_valid_o  <= 1'b0;
            res_ready_o <= 1'b1;
            state       <= WAIT_RES;
          end
        end
        WAIT_RES: begin
          if (res_valid_i && res_ready_o) begin
            res_ready_o <= 1'b0;
            tx_sh       <= res_pack;
            tx_left     <= TxCntW'(TxBytes - 1);
            tx_valid_o  <= 1'b1;
            state       <= SEND;
          end
        end
        SEND: begin
          if (tx_fire) begin
            tx_sh <= tx_sh << 8;
            if (tx_left == '0) begin
              tx_valid_o <= 1'b0;
              rx_ready_o <= 1'b1;
              state      <= IDLE;
            end else begin
              tx_left <= tx_left - TxCntW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_uart_cmd_framer.sv
// Directed bench for fp_uart_cmd_framer: a default-width instance (a) and a 3x16-bit instance (b).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_fp_uart_cmd_framer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  a_rx_data = '0, a_tx_data, a_op_code;
  logic        a_rx_valid = 1'b0, a_rx_ready, a_tx_valid, a_tx_ready = 1'b0;
  logic        a_op_valid, a_op_ready = 1'b0, a_res_valid = 1'b0, a_res_ready, a_frame_err;
  logic [63:0] a_op_data;
  logic [31:0] a_res_data = '0;

  logic [7:0]  b_rx_data = '0, b_tx_data, b_op_code;
  logic        b_rx_valid = 1'b0, b_rx_ready, b_tx_valid, b_tx_ready = 1'b0;
  logic        b_op_valid, b_op_ready = 1'b0, b_res_valid = 1'b0, b_res_ready, b_frame_err;
  logic [47:0] b_op_data;
  logic [15:0] b_res_data = '0;

  int errors = 0;
  int checks = 0;

  fp_uart_cmd_framer #(.TimeoutCycles(100)) dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .rx_data_i(a_rx_data), .rx_valid_i(a_rx_valid), .rx_ready_o(a_rx_ready),
    .tx_data_o(a_tx_data), .tx_valid_o(a_tx_valid), .tx_ready_i(a_tx_ready),
    .op_valid_o(a_op_valid), .op_ready_i(a_op_ready), .op_code_o(a_op_code), .op_data_o(a_op_data),
    .res_valid_i(a_res_valid), .res_ready_o(a_res_ready), .res_data_i(a_res_data),
    .frame_err_o(a_frame_err)
  );

  fp_uart_cmd_framer #(.OperandWidth(16), .NumOperands(3), .ResultWidth(16), .TimeoutCycles(100)) dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .rx_data_i(b_rx_data), .rx_valid_i(b_rx_valid), .rx_ready_o(b_rx_ready),
    .tx_data_o(b_tx_data), .tx_valid_o(b_tx_valid), .tx_ready_i(b_tx_ready),
    .op_valid_o(b_op_valid), .op_ready_i(b_op_ready), .op_code_o(b_op_code), .op_data_o(b_op_data),
    .res_valid_i(b_res_valid), .res_ready_o(b_res_ready), .res_data_i(b_res_data),
    .frame_err_o(b_frame_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic send_byte(input bit sel, input logic [7:0] b);
    bit ok = 1'b0;
    if (sel) begin b_rx_data = b; b_rx_valid = 1'b1; end
    else     begin a_rx_data = b; a_rx_valid = 1'b1; end
    for (int i = 0; i < 300 && !ok; i++) begin
      if (sel ? b_rx_ready : a_rx_ready) ok = 1'b1;
      @(negedge clk);
    end
    if (sel) b_rx_valid = 1'b0; else a_rx_valid = 1'b0;
    check("rx_handshake", ok, 1);
  endtask

  task automatic recv_byte(input bit sel, output logic [7:0] b);
    bit ok = 1'b0;
    b = '0;
    if (sel) b_tx_ready = 1'b1; else a_tx_ready = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (sel ? b_tx_valid : a_tx_valid) begin
        b  = sel ? b_tx_data : a_tx_data;
        ok = 1'b1;
      end
      @(negedge clk);
    end
    if (sel) b_tx_ready = 1'b0; else a_tx_ready = 1'b0;
    check("tx_handshake", ok, 1);
  endtask

  task automatic issue(input bit sel);
    if (sel) b_op_ready = 1'b1; else a_op_ready = 1'b1;
    @(negedge clk);
    if (sel) b_op_ready = 1'b0; else a_op_ready = 1'b0;
  endtask

  task automatic give_res(input bit sel, input logic [31:0] r);
    bit ok = 1'b0;
    if (sel) begin b_res_data = r[15:0]; b_res_valid = 1'b1; end
    else     begin a_res_data = r;       a_res_valid = 1'b1; end
    for (int i = 0; i < 300 && !ok; i++) begin
      if (sel ? b_res_ready : a_res_ready) ok = 1'b1;
      @(negedge clk);
    end
    if (sel) b_res_valid = 1'b0; else a_res_valid = 1'b0;
    check("res_handshake", ok, 1);
  endtask

  task automatic send_frame_a(input logic [7:0] opc, input logic [63:0] ops);
    logic [7:0] cs;
    cs = opc;
    send_byte(0, opc);
    for (int i = 0; i < 8; i++) begin
      send_byte(0, ops[63-8*i -: 8]);
      cs ^= ops[63-8*i -: 8];
    end
`ifdef FP_UART_CHECKSUM_EN
    send_byte(0, cs);
`endif
  endtask

  task automatic recv_res_a(input logic [31:0] r);
    logic [7:0] b;
`ifdef FP_UART_CHECKSUM_EN
    logic [7:0] rcs;
    rcs = '0;
`endif
    for (int i = 0; i < 4; i++) begin
      recv_byte(0, b);
      check("tx_byte", b, r[31-8*i -: 8]);
`ifdef FP_UART_CHECKSUM_EN
      rcs ^= r[31-8*i -: 8];
`endif
    end
`ifdef FP_UART_CHECKSUM_EN
    recv_byte(0, b);
    check("tx_csum", b, rcs);
`endif
    check("back_to_idle", a_rx_ready, 1);
  endtask

  task automatic do_txn_a(input logic [7:0] opc, input logic [63:0] ops, input logic [31:0] r);
    send_frame_a(opc, ops);
    check("op_valid_latency", a_op_valid, 1);
    check("op_code", a_op_code, opc);
    check("op_data", a_op_data, ops);
    issue(0);
    give_res(0, r);
    recv_res_a(r);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, {a_rx_ready, a_tx_valid, a_op_valid, a_res_ready, a_frame_err,
                           b_rx_ready, b_tx_valid, b_op_valid, b_res_ready, b_frame_err}, 0);
    check({tag, "_data"}, {a_tx_data, a_op_code, b_tx_data, b_op_code}, 0);
    check({tag, "_op_data"}, a_op_data, 0);
  endtask

  initial begin
    logic [7:0] b, cs;
    int bad, err_cnt, opv_cnt;

    // Reset state
    #1 check_reset_outputs("reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: 1.0 + 2.0 with a 3.0 result
    do_txn_a(8'h00, 64'h3F800000_40000000, 32'h40400000);

    // 2: held command, backpressured extra RX byte
    send_frame_a(8'h02, 64'h11223344_55667788);
    a_rx_data = 8'h55; a_rx_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (a_op_valid !== 1'b1 || a_op_data !== 64'h11223344_55667788 ||
          a_op_code !== 8'h02 || a_rx_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    check("hold_stable_cycles_bad", bad, 0);
    issue(0);
    give_res(0, 32'hDEADBEEF);
    recv_res_a(32'hDEADBEEF);
    send_byte(0, 8'h55);
    check("pending_byte_kept", a_op_code, 8'h55);

    // 5a: reset in the middle of COLLECT
    send_byte(0, 8'hAA);
    send_byte(0, 8'hBB);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_collect");
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
    do_txn_a(8'h07, 64'hC0490FDB_3DCCCCCD, 32'hBF000000);

    // 5b: reset in the middle of SEND
    send_frame_a(8'h03, 64'h01020304_05060708);
    issue(0);
    give_res(0, 32'h89ABCDEF);
    recv_byte(0, b);
    check("send_first_byte", b, 8'h89);
    check("send_in_progress", a_tx_valid, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_send");
    @(negedge clk); rst_n = 1'b1; @(negedge clk);

    // 3: inter-byte timeout after 5 bytes
    send_byte(0, 8'h01);
    for (int i = 0; i < 4; i++) send_byte(0, 8'h10 + 8'(i));
    err_cnt = 0; opv_cnt = 0;
    for (int i = 1; i <= 130; i++) begin
      @(negedge clk);
      if (a_frame_err) err_cnt++;
      if (a_op_valid) opv_cnt++;
      if (i == 90) check("timeout_not_early", err_cnt, 0);
    end
    check("timeout_pulses", err_cnt, 1);
    check("timeout_no_op", opv_cnt, 0);
    do_txn_a(8'h00, 64'h3F800000_40000000, 32'h40400000);

    // 4: 3 x 16-bit operands, 16-bit result
    cs = 8'h01;
    send_byte(1, 8'h01);
    foreach (b_op_data[i]) begin end
    for (int i = 0; i < 6; i++) begin
      b = (i < 2) ? 8'h11 : (i < 4) ? 8'h22 : 8'h33;
      send_byte(1, b);
      cs ^= b;
    end
`ifdef FP_UART_CHECKSUM_EN
    send_byte(1, cs);
`endif
    check("b_op_valid", b_op_valid, 1);
    check("b_op_code", b_op_code, 8'h01);
    check("b_op_data", b_op_data, 48'h1111_2222_3333);
    issue(1);
    give_res(1, 32'h0000ABCD);
    recv_byte(1, b); check("b_tx_byte0", b, 8'hAB);
    recv_byte(1, b); check("b_tx_byte1", b, 8'hCD);
`ifdef FP_UART_CHECKSUM_EN
    recv_byte(1, b); check("b_tx_csum", b, 8'h66);
`endif
    check("b_back_to_idle", b_rx_ready, 1);

`ifdef FP_UART_CHECKSUM_EN
    // 6: wrong checksum -> error byte, no command; then correct checksum
    send_byte(0, 8'h00);
    for (int i = 0; i < 8; i++) send_byte(0, (i == 0) ? 8'h3F : (i == 1) ? 8'h80 : (i == 4) ? 8'h40 : 8'h00);
    send_byte(0, 8'h00);
    check("cs_frame_err", a_frame_err, 1);
    check("cs_no_op", a_op_valid, 0);
    recv_byte(0, b);
    check("cs_err_byte", b, 8'hEE);
    check("cs_back_to_idle", a_rx_ready, 1);
    do_txn_a(8'h00, 64'h3F800000_40000000, 32'h40400000);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
